// File: rtl/dmem_responder_if.sv
// Core-to-data-memory bus: request/store fields from the core, load data and stall back.
// MemErr exists only when DMEM_RESPONDER_ERR_EN is defined.
interface dmem_responder_if;
    logic        MemStrobe;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        PCReady;
`ifdef DMEM_RESPONDER_ERR_EN
    logic        MemErr;

    modport master (
        output MemStrobe, MemWrite, ALUResult, WriteData,
        input  ReadData, PCReady, MemErr
    );
    modport slave (
        input  MemStrobe, MemWrite, ALUResult, WriteData,
        output ReadData, PCReady, MemErr
    );
`else
    modport master (
        output MemStrobe, MemWrite, ALUResult, WriteData,
        input  ReadData, PCReady
    );
    modport slave (
        input  MemStrobe, MemWrite, ALUResult, WriteData,
        output ReadData, PCReady
    );
`endif
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data RAM responder that stalls the core's PC until each access completes.
// Optional DMEM_RESPONDER_ERR_EN: flag out-of-range addresses instead of wrapping them.
module dmem_responder #(
    parameter int WORDS   = 64,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus
);

    localparam int IDXW = $clog2(WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t            state, state_next;
    logic [1:0]        cnt, cnt_next;
    logic [IDXW-1:0]   idx, idx_next;
    logic [IDXW-1:0]   addr_idx;
    logic              err_q;
    logic              addr_err;
    logic              acc_err;
    logic              load;
    logic              mem_we;
    logic              pc_ready;
    logic [31:0]       read_data;
    logic [31:0]       mem [WORDS];

    assign addr_idx = bus.ALUResult[IDXW+1:2];

`ifdef DMEM_RESPONDER_ERR_EN
    assign addr_err   = |bus.ALUResult[31:IDXW+2];
    assign bus.MemErr = reset && (state == DONE) && err_q;
`else
    assign addr_err = 1'b0;
`endif

    // The error flag is not registered yet on the accept edge itself (LATENCY==1 path).
    assign acc_err = (state == IDLE) ? addr_err : err_q;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        load       = 1'b0;
        mem_we     = 1'b0;
        pc_ready   = 1'b0;
        case (state)
            IDLE: begin
                pc_ready = ~bus.MemStrobe;
                if (bus.MemStrobe) begin
                    idx_next = addr_idx;
                    if (LATENCY == 1) begin
                        state_next = DONE;
                        load       = 1'b1;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = 2'(LATENCY - 2);
                    end
                end
            end
            WAIT: begin
                if (!bus.MemStrobe) begin
                    state_next = IDLE;
                end else if (cnt == 2'd0) begin
                    state_next = DONE;
                    load       = 1'b1;
                end else begin
                    cnt_next = cnt - 2'd1;
                end
            end
            DONE: begin
                pc_ready   = 1'b1;
                state_next = IDLE;
                mem_we     = bus.MemStrobe && bus.MemWrite && !err_q;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            idx       <= '0;
            err_q     <= 1'b0;
            read_data <= 32'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            idx   <= idx_next;
            if (state == IDLE && bus.MemStrobe)
                err_q <= addr_err;
            if (load)
                read_data <= acc_err ? 32'hDEADBEEF : mem[idx_next];
        end
    end

    // RAM contents survive reset; only the write strobe is gated by it.
    always_ff @(posedge clk) begin
        if (reset && mem_we)
            mem[idx] <= bus.WriteData;
    end

    assign bus.ReadData = read_data;
    assign bus.PCReady  = reset && pc_ready;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 and LATENCY=1 instances on a shared clock/reset.
// Expectations switch on DMEM_RESPONDER_ERR_EN for the out-of-range address case.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dmem_responder_if bus2 ();
    dmem_responder_if bus1 ();

    dmem_responder #(.WORDS(64), .LATENCY(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));
    dmem_responder #(.WORDS(64), .LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int sel, input logic strobe, input logic we,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        if (sel == 1) begin
            bus1.MemStrobe = strobe;
            bus1.MemWrite  = we;
            bus1.ALUResult = addr;
            bus1.WriteData = wdata;
        end else begin
            bus2.MemStrobe = strobe;
            bus2.MemWrite  = we;
            bus2.ALUResult = addr;
            bus2.WriteData = wdata;
        end
    endtask

    function automatic logic [31:0] rdOf(input int sel);
        return (sel == 1) ? bus1.ReadData : bus2.ReadData;
    endfunction

    function automatic logic [31:0] pcrOf(input int sel);
        return {31'd0, (sel == 1) ? bus1.PCReady : bus2.PCReady};
    endfunction

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // One full access with the strobe held for LATENCY+1 cycles; called just after a rising edge.
    task automatic access(input int sel, input int lat, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic chkRd, input logic [31:0] expRd,
                          input string tag);
        for (int c = 0; c <= lat; c++) begin
            applyStimulus(sel, 1'b1, we, addr, wdata);
            #3;
            checkOutput({tag, "_pcr"}, pcrOf(sel), (c == lat) ? 32'd1 : 32'd0);
            if (c == lat && chkRd)
                checkOutput({tag, "_rd"}, rdOf(sel), expRd);
            nextCycle();
        end
        applyStimulus(sel, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        // Reset held two cycles with a pending strobe, then with strobe low.
        reset = 1'b0;
        applyStimulus(2, 1'b1, 1'b0, 32'h10, 32'd0);
        applyStimulus(1, 1'b1, 1'b0, 32'h10, 32'd0);
        nextCycle();
        #3;
        checkOutput("rst_pcr_a", pcrOf(2), 32'd0);
        checkOutput("rst_rd_a", rdOf(2), 32'd0);
        applyStimulus(2, 1'b0, 1'b0, 32'd0, 32'd0);
        applyStimulus(1, 1'b0, 1'b0, 32'd0, 32'd0);
        nextCycle();
        #3;
        checkOutput("rst_pcr_b", pcrOf(2), 32'd0);
        checkOutput("rst_pcr_l1", pcrOf(1), 32'd0);
        nextCycle();
        reset = 1'b1;
        #3;
        checkOutput("rel_pcr", pcrOf(2), 32'd1);
        checkOutput("rel_pcr_l1", pcrOf(1), 32'd1);
        checkOutput("rel_rd", rdOf(2), 32'd0);
        nextCycle();

        // Store then load at 0x10.
        access(2, 2, 1'b1, 32'h10, 32'h12345678, 1'b0, 32'd0, "str10");
        access(2, 2, 1'b0, 32'h10, 32'd0, 1'b1, 32'h12345678, "ldr10");
        #3;
        checkOutput("rd_hold", rdOf(2), 32'h12345678);
        checkOutput("idle_pcr", pcrOf(2), 32'd1);
        nextCycle();

        // MemWrite high only before DONE must not write.
        access(2, 2, 1'b1, 32'h20, 32'h00000000, 1'b0, 32'd0, "str20");
        for (int c = 0; c < 3; c++) begin
            applyStimulus(2, 1'b1, (c < 2), 32'h20, 32'h77777777);
            nextCycle();
        end
        applyStimulus(2, 1'b0, 1'b0, 32'd0, 32'd0);
        access(2, 2, 1'b0, 32'h20, 32'd0, 1'b1, 32'h00000000, "ldr20");

        // Abort a store in WAIT.
        access(2, 2, 1'b1, 32'h04, 32'h11111111, 1'b0, 32'd0, "str04");
        access(2, 2, 1'b0, 32'h04, 32'd0, 1'b1, 32'h11111111, "ldr04");
        applyStimulus(2, 1'b1, 1'b1, 32'h04, 32'hAAAA5555);
        nextCycle();
        applyStimulus(2, 1'b0, 1'b1, 32'h04, 32'hAAAA5555);
        #3;
        checkOutput("abort_wait_pcr", pcrOf(2), 32'd0);
        nextCycle();
        #3;
        checkOutput("abort_idle_pcr", pcrOf(2), 32'd1);
        checkOutput("abort_rd", rdOf(2), 32'h11111111);
        nextCycle();
        access(2, 2, 1'b0, 32'h04, 32'd0, 1'b1, 32'h11111111, "abort_ldr");

        // Out-of-range address: wrap or error depending on build.
`ifdef DMEM_RESPONDER_ERR_EN
        for (int c = 0; c < 3; c++) begin
            applyStimulus(2, 1'b1, 1'b1, 32'h104, 32'hCAFEF00D);
            #3;
            checkOutput("err_pcr", pcrOf(2), (c == 2) ? 32'd1 : 32'd0);
            checkOutput("err_flag", {31'd0, bus2.MemErr}, (c == 2) ? 32'd1 : 32'd0);
            if (c == 2)
                checkOutput("err_rd", rdOf(2), 32'hDEADBEEF);
            nextCycle();
        end
        applyStimulus(2, 1'b0, 1'b0, 32'd0, 32'd0);
        #3;
        checkOutput("err_flag_idle", {31'd0, bus2.MemErr}, 32'd0);
        nextCycle();
        access(2, 2, 1'b0, 32'h004, 32'd0, 1'b1, 32'h11111111, "err_nowrite");
        access(2, 2, 1'b0, 32'h104, 32'd0, 1'b1, 32'hDEADBEEF, "err_ldr");
`else
        access(2, 2, 1'b1, 32'h104, 32'hCAFEF00D, 1'b0, 32'd0, "wrap_str");
        access(2, 2, 1'b0, 32'h004, 32'd0, 1'b1, 32'hCAFEF00D, "wrap_ldr");
`endif

        // Reset during the DONE cycle of a store: no write, ReadData cleared.
        access(2, 2, 1'b0, 32'h10, 32'd0, 1'b1, 32'h12345678, "pre_rst");
        applyStimulus(2, 1'b1, 1'b1, 32'h10, 32'h99999999);
        nextCycle();
        nextCycle();
        reset = 1'b0;
        #3;
        checkOutput("rstmid_pcr", pcrOf(2), 32'd0);
        nextCycle();
        reset = 1'b1;
        applyStimulus(2, 1'b0, 1'b0, 32'd0, 32'd0);
        #3;
        checkOutput("rstmid_rd", rdOf(2), 32'd0);
        checkOutput("rstmid_idle", pcrOf(2), 32'd1);
        nextCycle();
        access(2, 2, 1'b0, 32'h10, 32'd0, 1'b1, 32'h12345678, "rstmid_ldr");

        // LATENCY=1 instance: back-to-back stores and loads, no idle bubble.
        access(1, 1, 1'b1, 32'h0, 32'h0A0A0A0A, 1'b0, 32'd0, "l1_str0");
        access(1, 1, 1'b1, 32'h4, 32'h0B0B0B0B, 1'b0, 32'd0, "l1_str4");
        access(1, 1, 1'b0, 32'h0, 32'd0, 1'b1, 32'h0A0A0A0A, "b2b0");
        access(1, 1, 1'b0, 32'h4, 32'd0, 1'b1, 32'h0B0B0B0B, "b2b1");
        #3;
        checkOutput("l1_hold", rdOf(1), 32'h0B0B0B0B);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
